// File: rtl/output_unloader_pkg.sv
// Shared constants and state encoding for the output-memory unload path.
package tpu_pkg;

   localparam int WIDTH_HEIGHT = 16;
   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      STREAM = 2'd3
   } unload_state_t;

endpackage

// File: rtl/output_unloader_if.sv
// Host-side result stream: one word per valid/ready transfer, tagged with
// its row address, column index and an end-of-unload marker.
interface output_unloader_if #(
   parameter int DATA_W = tpu_pkg::DATA_W,
   parameter int ADDR_W = tpu_pkg::ADDR_W,
   parameter int COL_W  = $clog2(tpu_pkg::WIDTH_HEIGHT)
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_row;
   logic [COL_W-1:0]  out_col;
   logic              out_last;

   modport master (
      output out_valid, out_data, out_row, out_col, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_row, out_col, out_last,
      output out_ready
   );
endinterface

// File: rtl/output_unloader_row_buffer.sv
// One-row capture buffer with a column read mux.
// Build option OUTPUT_UNLOADER_RELU_EN: clamp negative (signed) words to zero
// on the way out; the stored row is always the raw memory data.
module output_row_buffer #(
   parameter int WIDTH_HEIGHT = tpu_pkg::WIDTH_HEIGHT,
   parameter int DATA_W       = tpu_pkg::DATA_W,
   parameter int COL_W        = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           load,
   input  logic [WIDTH_HEIGHT*DATA_W-1:0] row_data,
   input  logic [COL_W-1:0]               col,
   output logic [DATA_W-1:0]              word
);
   logic [DATA_W-1:0] row_q [WIDTH_HEIGHT];
   logic [DATA_W-1:0] raw_word;

   // Capture every lane of the returned row in one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WIDTH_HEIGHT; i++) row_q[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < WIDTH_HEIGHT; i++) row_q[i] <= row_data[i*DATA_W +: DATA_W];
      end
   end

   assign raw_word = row_q[col];

`ifdef OUTPUT_UNLOADER_RELU_EN
   assign word = raw_word[DATA_W-1] ? '0 : raw_word;
`else
   assign word = raw_word;
`endif

endmodule

// File: rtl/output_unloader.sv
// Output-memory unload engine: reads consecutive rows from the per-lane
// output memory and streams each row to the host one word at a time.
// Build option OUTPUT_UNLOADER_RELU_EN is handled in output_row_buffer.
//
//   state  | meaning
//   IDLE   | waiting for start; zero-row start just pulses done
//   ISSUE  | one-cycle read of cur_addr on every lane
//   WAIT   | read latency; last WAIT edge loads the row buffer
//   STREAM | out_valid high, one column per accepted transfer
module output_unloader #(
   parameter int WIDTH_HEIGHT = tpu_pkg::WIDTH_HEIGHT,
   parameter int ADDR_W       = tpu_pkg::ADDR_W,
   parameter int DATA_W       = tpu_pkg::DATA_W,
   parameter int RD_LATENCY   = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [ADDR_W:0]                row_count,
   output logic                           busy,
   output logic                           done,
   output logic [WIDTH_HEIGHT-1:0]        outputMem_rd_en,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_rd_addr,
   input  logic [WIDTH_HEIGHT*DATA_W-1:0] outputMem_rd_data,
   output_unloader_if.master              out_bus
);
   import tpu_pkg::*;

   localparam int COL_W = (WIDTH_HEIGHT > 1) ? $clog2(WIDTH_HEIGHT) : 1;
   localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(WIDTH_HEIGHT - 1);
   localparam logic [ADDR_W:0]   ONE_ROW  = (ADDR_W+1)'(1);
   localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LATENCY - 1);

   unload_state_t     state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W:0]   rows_left;
   logic [COL_W-1:0]  col;
   logic [LAT_W-1:0]  wait_cnt;
   logic              out_valid_q;
   logic              load_row;
   logic [DATA_W-1:0] row_word;

   assign next_addr = cur_addr + ADDR_W'(1);
   assign load_row  = (state == WAIT) && (wait_cnt == '0);

   // Sequencer: read issue, latency countdown, per-word streaming, completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         cur_addr          <= '0;
         rows_left         <= '0;
         col               <= '0;
         wait_cnt          <= '0;
         out_valid_q       <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         outputMem_rd_en   <= '0;
         outputMem_rd_addr <= '0;
      end else begin
         done            <= 1'b0;
         outputMem_rd_en <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (row_count != '0) begin
                     cur_addr          <= base_addr;
                     rows_left         <= row_count;
                     busy              <= 1'b1;
                     outputMem_rd_en   <= '1;
                     outputMem_rd_addr <= {WIDTH_HEIGHT{base_addr}};
                     state             <= ISSUE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= LAT_LOAD;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  col         <= '0;
                  out_valid_q <= 1'b1;
                  state       <= STREAM;
               end else begin
                  wait_cnt <= wait_cnt - LAT_W'(1);
               end
            end
            STREAM: begin
               if (out_bus.out_ready) begin
                  if (col != LAST_COL) begin
                     col <= col + COL_W'(1);
                  end else begin
                     rows_left   <= rows_left - ONE_ROW;
                     out_valid_q <= 1'b0;
                     if (rows_left != ONE_ROW) begin
                        cur_addr          <= next_addr;
                        outputMem_rd_en   <= '1;
                        outputMem_rd_addr <= {WIDTH_HEIGHT{next_addr}};
                        state             <= ISSUE;
                     end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   output_row_buffer #(
      .WIDTH_HEIGHT (WIDTH_HEIGHT),
      .DATA_W       (DATA_W),
      .COL_W        (COL_W)
   ) u_row_buffer (
      .clk      (clk),
      .reset    (reset),
      .load     (load_row),
      .row_data (outputMem_rd_data),
      .col      (col),
      .word     (row_word)
   );

   assign out_bus.out_valid = out_valid_q;
   assign out_bus.out_data  = row_word;
   assign out_bus.out_row   = cur_addr;
   assign out_bus.out_col   = col;
   assign out_bus.out_last  = out_valid_q && (col == LAST_COL) && (rows_left == ONE_ROW);

endmodule

// File: tb/tb_output_unloader.sv
// Scoreboard bench for output_unloader: the stimulus side pushes the words
// and read addresses an unload should produce; a negedge monitor pops and
// compares whatever the DUT presents.
module tb_output_unloader;
   localparam int WH = 16;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW-1:0]   base_addr;
   logic [AW:0]     row_count;
   logic            busy;
   logic            done;
   logic [WH-1:0]   rd_en;
   logic [WH*AW-1:0] rd_addr;
   logic [WH*DW-1:0] rd_data;

   output_unloader_if #(.DATA_W(DW), .ADDR_W(AW), .COL_W(CW)) bus ();

   output_unloader #(
      .WIDTH_HEIGHT (WH),
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .RD_LATENCY   (1)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .base_addr         (base_addr),
      .row_count         (row_count),
      .busy              (busy),
      .done              (done),
      .outputMem_rd_en   (rd_en),
      .outputMem_rd_addr (rd_addr),
      .outputMem_rd_data (rd_data),
      .out_bus           (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [AW-1:0] row;
      logic [CW-1:0] col;
      logic          last;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] iss_q[$];
   logic [DW-1:0] mem [WH][256];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int done_due    = -1;
   int issue_cnt   = 0;
   int rdy_mode    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output memory, one-cycle synchronous read per lane.
   always @(posedge clk) begin
      for (int c = 0; c < WH; c++)
         if (rd_en[c]) rd_data[c*DW +: DW] <= mem[c][rd_addr[c*AW +: AW]];
   end

   function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef OUTPUT_UNLOADER_RELU_EN
      return ($signed(w) < 0) ? '0 : w;
`else
      return w;
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got an unexpected event, expected none (cycle %0d)", name, cyc);
   endtask

   // Ready generator: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
   initial begin
      int ph;
      ph = 0;
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: begin
               bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
               ph++;
            end
            2: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] s_data;
   logic [AW-1:0] s_row;
   logic [CW-1:0] s_col;
   logic          s_last;
   exp_t          e;
   logic [AW-1:0] a;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (rd_en != '0) begin
            issue_cnt++;
            if (iss_q.size() == 0) begin
               fail_now("issue_unexpected");
            end else begin
               a = iss_q.pop_front();
               chk("issue_en", 128'(rd_en), 128'({WH{1'b1}}));
               chk("issue_addr", 128'(rd_addr), 128'({WH{a}}));
            end
         end
         if (prev_stall)
            chk("stall_hold", {bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_last},
                              {1'b1, s_data, s_row, s_col, s_last});
         if (bus.out_valid) chk("busy_while_valid", 128'(busy), 128'(1));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("xfer_unexpected");
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 128'(bus.out_data), 128'(e.data));
               chk("out_row",  128'(bus.out_row),  128'(e.row));
               chk("out_col",  128'(bus.out_col),  128'(e.col));
               chk("out_last", 128'(bus.out_last), 128'(e.last));
               if (e.last) done_due = cyc + 1;
            end
         end
         if (done || (cyc == done_due)) begin
            chk("done_timing", 128'(done), 128'(cyc == done_due));
            if (done) chk("busy_at_done", 128'(busy), 128'(0));
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         s_data = bus.out_data;
         s_row  = bus.out_row;
         s_col  = bus.out_col;
         s_last = bus.out_last;
      end
   end

   task automatic start_unload(input logic [AW-1:0] b, input int n, output int c0);
      logic [AW-1:0] ra;
      for (int r = 0; r < n; r++) begin
         ra = b + AW'(r);
         iss_q.push_back(ra);
         for (int c = 0; c < WH; c++) begin
            exp_t x;
            x.data = model_word(mem[c][ra]);
            x.row  = ra;
            x.col  = CW'(c);
            x.last = (r == n - 1) && (c == WH - 1);
            exp_q.push_back(x);
         end
      end
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = b;
      row_count = (AW+1)'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      c0    = cyc;
      if (n == 0) done_due = c0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk({name, "_done_seen"}, 128'(k < budget), 128'(1));
      chk({name, "_words_left"}, 128'(exp_q.size()), 128'(0));
      chk({name, "_issues_left"}, 128'(iss_q.size()), 128'(0));
      exp_q.delete();
      iss_q.delete();
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_busy"},      128'(busy),          128'(0));
      chk({name, "_done"},      128'(done),          128'(0));
      chk({name, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      chk({name, "_out_last"},  128'(bus.out_last),  128'(0));
      chk({name, "_out_data"},  128'(bus.out_data),  128'(0));
      chk({name, "_out_row"},   128'(bus.out_row),   128'(0));
      chk({name, "_out_col"},   128'(bus.out_col),   128'(0));
      chk({name, "_rd_en"},     128'(rd_en),         128'(0));
      chk({name, "_rd_addr"},   128'(rd_addr),       128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int c0;
      int found;
      for (int c = 0; c < WH; c++)
         for (int r = 0; r < 256; r++) mem[c][r] = DW'($urandom);
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      row_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("por");
      reset = 1'b0;

      // Single row, known data, latency check.
      for (int c = 0; c < WH; c++) mem[c][0] = DW'(16'h0100 + c);
      rdy_mode = 0;
      start_unload(8'h00, 1, c0);
      @(negedge clk);
      chk("t1_issue_cycle", 128'(rd_en), 128'({WH{1'b1}}));
      @(negedge clk);
      chk("t1_valid_in_wait", 128'(bus.out_valid), 128'(0));
      @(negedge clk);
      chk("t1_first_valid", 128'(bus.out_valid), 128'(1));
      chk("t1_first_word", 128'(bus.out_data), 128'(16'h0100));
      wait_done("t1", 100);

      // Wrapping addresses, plus a start pulse while busy that must be ignored.
      issue_cnt = 0;
      start_unload(8'hFE, 3, c0);
      repeat (5) @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = 8'h55;
      row_count = 9'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t2", 300);
      chk("t2_issue_count", 128'(issue_cnt), 128'(3));

      // Stall pattern 1,0,0,1.
      rdy_mode = 1;
      start_unload(8'h30, 2, c0);
      wait_done("t3", 400);
      rdy_mode = 0;

      // Zero rows: done only.
      start_unload(8'h12, 0, c0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_busy", 128'(busy), 128'(0));
         chk("t4_valid", 128'(bus.out_valid), 128'(0));
         chk("t4_rd_en", 128'(rd_en), 128'(0));
      end

      // Reset at column 7 of the second row, then a fresh unload.
      start_unload(8'h20, 3, c0);
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_row == 8'h21 && bus.out_col == 4'd7) found = 1;
      end
      chk("t5_reached_col7", 128'(found), 128'(1));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("t5_rst");
      exp_q.delete();
      iss_q.delete();
      done_due = -1;
      reset = 1'b0;
      start_unload(8'h10, 2, c0);
      wait_done("t5", 200);

      // Sign-boundary words.
      mem[0][8'h40] = 16'hFFFF;
      mem[1][8'h40] = 16'h8000;
      mem[2][8'h40] = 16'h7FFF;
      start_unload(8'h40, 1, c0);
      wait_done("t6", 100);

      // Full 256-row sweep.
      start_unload(8'h80, 256, c0);
      wait_done("t7", 256 * 18 + 100);

      // Randomized unloads with random backpressure.
      for (int i = 0; i < 6; i++) begin
         rdy_mode = $urandom_range(0, 2);
         start_unload(AW'($urandom), $urandom_range(1, 3), c0);
         wait_done("rnd", 600);
      end
      rdy_mode = 0;

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
